mod_addsub_pipe: RTL

//  Pipelined modular add/sub unit. Consumes operands in [0,q), produces fully reduced (a+b) mod q or (a-b) mod q.

---
 rtl/pqcuark_ntt_pkg.sv | 23 ++
 rtl/mod_lane_correct.sv | 23 ++
 rtl/mod_addsub_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pqcuark_ntt_pkg.sv
// Shared NTT datapath definitions: moduli, add/sub opcode and stage-1 payload.
package pqcuark_ntt_pkg;

  localparam int unsigned KYBER_Q_C     = 3329;
  localparam int unsigned DILITHIUM_Q_C = 8380417;
  localparam int unsigned LANE_W_C      = 16;
  localparam int unsigned WORD_W_C      = 32;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  // Raw adder/subtractor output awaiting modular correction.
  // flags[0]: carry/borrow of lane lo (or of the 32-bit word); flags[1]: lane hi.
  typedef struct packed {
    logic [WORD_W_C-1:0] raw;
    logic [1:0]          flags;
    logic                selKD;
    addsub_op_e          op;
  } addsub_s1_t;

endpackage

// File: rtl/mod_lane_correct.sv
// Combinational final correction of one raw lane into [0,q).
// Add: subtract q when carry/sum reaches q. Sub: add q back when a borrow occurred.
module mod_lane_correct #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] raw_i,
  input  logic         flag_i,
  input  logic         sub_i,
  input  logic [W-1:0] q_i,
  output logic [W-1:0] res_c_o
);

  // Select the corrected value; arithmetic wraps at the lane width.
  always_comb begin
    res_c_o = raw_i;
    if (sub_i) begin
      if (flag_i) res_c_o = raw_i + q_i;
    end else if ({flag_i, raw_i} >= {1'b0, q_i}) begin
      res_c_o = raw_i - q_i;
    end
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular add/sub: Kyber 2x16 (q=3329) or Dilithium 1x32 (q=8380417).
// Optional operand range check enabled by defining MOD_ADDSUB_RANGE_CHK_EN.
module mod_addsub_pipe
  import pqcuark_ntt_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                selKD_i,
  input  logic                op_i,
  input  logic [WORD_W_C-1:0] srcA_i,
  input  logic [WORD_W_C-1:0] srcB_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [WORD_W_C-1:0] result_o
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  ,
  output logic                range_err_o
`endif
);

  localparam logic [LANE_W_C-1:0] KQ_C = LANE_W_C'(KYBER_Q_C);
  localparam logic [WORD_W_C-1:0] DQ_C = WORD_W_C'(DILITHIUM_Q_C);

  logic                s1_valid_q, s1_valid_d;
  addsub_s1_t          s1_q, s1_d;
  logic                valid_q, valid_d;
  logic [WORD_W_C-1:0] result_q, result_d;

  logic                s2_free;
  logic                s1_adv;
  logic                in_fire;

  logic [LANE_W_C:0]   lo_raw, hi_raw;
  logic [WORD_W_C:0]   wd_raw;

  logic [LANE_W_C-1:0] hi_res;
  logic [WORD_W_C-1:0] sh_raw, sh_q, sh_res;
  logic [WORD_W_C-1:0] corr;

  // Handshake: combinational ready, no skid buffer.
  assign s2_free = !valid_q || ready_i;
  assign s1_adv  = s1_valid_q && s2_free;
  assign ready_o = !s1_valid_q || s2_free;
  assign in_fire = valid_i && ready_o;

  // Raw lane-isolated (Kyber) and full-width (Dilithium) add/sub with carry/borrow.
  always_comb begin
    lo_raw = '0;
    hi_raw = '0;
    wd_raw = '0;
    if (op_i) begin
      lo_raw = {1'b0, srcA_i[LANE_W_C-1:0]} - {1'b0, srcB_i[LANE_W_C-1:0]};
      hi_raw = {1'b0, srcA_i[WORD_W_C-1:LANE_W_C]} - {1'b0, srcB_i[WORD_W_C-1:LANE_W_C]};
      wd_raw = {1'b0, srcA_i} - {1'b0, srcB_i};
    end else begin
      lo_raw = {1'b0, srcA_i[LANE_W_C-1:0]} + {1'b0, srcB_i[LANE_W_C-1:0]};
      hi_raw = {1'b0, srcA_i[WORD_W_C-1:LANE_W_C]} + {1'b0, srcB_i[WORD_W_C-1:LANE_W_C]};
      wd_raw = {1'b0, srcA_i} + {1'b0, srcB_i};
    end
  end

  // Stage-1 next state: load on input transfer, empty when handed to stage 2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_d.selKD = selKD_i;
      s1_d.op    = addsub_op_e'(op_i);
      if (selKD_i) begin
        s1_d.raw   = {hi_raw[LANE_W_C-1:0], lo_raw[LANE_W_C-1:0]};
        s1_d.flags = {hi_raw[LANE_W_C], lo_raw[LANE_W_C]};
      end else begin
        s1_d.raw   = wd_raw[WORD_W_C-1:0];
        s1_d.flags = {1'b0, wd_raw[WORD_W_C]};
      end
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  // Shared corrector serves Kyber lane lo and the Dilithium word.
  assign sh_raw = s1_q.selKD ? {{LANE_W_C{1'b0}}, s1_q.raw[LANE_W_C-1:0]} : s1_q.raw;
  assign sh_q   = s1_q.selKD ? {{LANE_W_C{1'b0}}, KQ_C} : DQ_C;

  mod_lane_correct #(.W(LANE_W_C)) u_corr_hi (
    .raw_i   (s1_q.raw[WORD_W_C-1:LANE_W_C]),
    .flag_i  (s1_q.flags[1]),
    .sub_i   (s1_q.op == OP_SUB),
    .q_i     (KQ_C),
    .res_c_o (hi_res)
  );

  mod_lane_correct #(.W(WORD_W_C)) u_corr_sh (
    .raw_i   (sh_raw),
    .flag_i  (s1_q.flags[0]),
    .sub_i   (s1_q.op == OP_SUB),
    .q_i     (sh_q),
    .res_c_o (sh_res)
  );

  assign corr = s1_q.selKD ? {hi_res, sh_res[LANE_W_C-1:0]} : sh_res;

  // Stage-2 next state: capture corrected result, hold while downstream stalls.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    if (s1_adv) begin
      valid_d  = 1'b1;
      result_d = corr;
    end else if (ready_i) begin
      valid_d  = 1'b0;
    end
  end

  // Stage-2 registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;

`ifdef MOD_ADDSUB_RANGE_CHK_EN
  logic rng_in, rng_s1_q, rng_s1_d, rng_s2_q, rng_s2_d;

  assign rng_in = selKD_i ?
                  ((srcA_i[LANE_W_C-1:0] >= KQ_C) || (srcA_i[WORD_W_C-1:LANE_W_C] >= KQ_C) ||
                   (srcB_i[LANE_W_C-1:0] >= KQ_C) || (srcB_i[WORD_W_C-1:LANE_W_C] >= KQ_C)) :
                  ((srcA_i >= DQ_C) || (srcB_i >= DQ_C));

  // Range flag travels with its operation through both stages.
  always_comb begin
    rng_s1_d = rng_s1_q;
    rng_s2_d = rng_s2_q;
    if (in_fire) rng_s1_d = rng_in;
    if (s1_adv)  rng_s2_d = rng_s1_q;
  end

  // Range flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rng_s1_q <= 1'b0;
      rng_s2_q <= 1'b0;
    end else begin
      rng_s1_q <= rng_s1_d;
      rng_s2_q <= rng_s2_d;
    end
  end

  assign range_err_o = rng_s2_q;
`endif

endmodule
